// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The master issues a request and holds it until ack; the slave returns rdata alongside ack.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage with MEM/WB register: aligns stores, extends loads, stalls on a
// variable-latency req/ack data bus, and flags misaligned accesses or bus timeouts.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  WriteSrc_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] WriteData_i,
  input  logic [31:0] pcPlus4_i,
  input  logic [31:0] ImmOp_i,
  input  logic [4:0]  rd_i,
  mem_stage_lsu_if.master dmem,
  output logic        stall_o,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic [1:0]  WriteSrc_o,
  output logic [31:0] ALUout_o,
  output logic [31:0] DataMemOut_o,
  output logic [31:0] pcPlus4_o,
  output logic [31:0] ImmOp_o,
  output logic [4:0]  rd_o,
  output logic        fault_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  // 0 byte, 1 half, 2 word; undefined encodings fall back to word
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 2'd0;
      3'b001, 3'b101: return 2'd1;
      default:        return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic signed [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [31:0] word);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, sh[7:0]};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0]         size;
  logic [1:0]         off;
  logic               mem_op, misaligned, timeout;
  logic               req, fault_n, done;
  logic signed [31:0] load_data;

  logic        vld_p1, RegWrite_p1, fault_p1;
  logic [1:0]  WriteSrc_p1;
  logic [31:0] ALUout_p1, DataMemOut_p1, pcPlus4_p1, ImmOp_p1;
  logic [4:0]  rd_p1;

  assign size       = access_size(funct3_i);
  assign off        = ALUout_i[1:0];
  assign mem_op     = valid_i & (MemRead_i | MemWrite_i);
  assign misaligned = ((size == 2'd1) & off[0]) | ((size == 2'd2) & (off != 2'b00));
  assign timeout    = (state == WAIT) & ~dmem.ack & (TIMEOUT_CYCLES != 0)
                    & (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign load_data  = load_extend(funct3_i, off, dmem.rdata);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req     = 1'b0;
    fault_n = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            fault_n = 1'b1;
          end else begin
            req = 1'b1;
            if (!dmem.ack) begin
              state_n = WAIT;
              cnt_n   = CNT_W'(1);
            end
          end
        end
      end
      WAIT: begin
        if (dmem.ack) begin
          req     = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (timeout) begin
          fault_n = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          req   = 1'b1;
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // An abandoned request is withdrawn in the reset cycle itself
    if (rst) req = 1'b0;
  end

  assign done    = req & dmem.ack;
  assign stall_o = req & ~dmem.ack;

  assign dmem.req   = req;
  assign dmem.we    = MemWrite_i;
  assign dmem.addr  = {ALUout_i[31:2], 2'b00};
  assign dmem.be    = lane_be(size, off);
  assign dmem.wdata = lane_wdata(size, WriteData_i);

  // MEM/WB boundary: a bubble is loaded while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      vld_p1        <= 1'b0;
      RegWrite_p1   <= 1'b0;
      fault_p1      <= 1'b0;
      WriteSrc_p1   <= '0;
      ALUout_p1     <= '0;
      DataMemOut_p1 <= '0;
      pcPlus4_p1    <= '0;
      ImmOp_p1      <= '0;
      rd_p1         <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      vld_p1        <= valid_i & ~stall_o;
      RegWrite_p1   <= valid_i & RegWrite_i & ~stall_o & ~fault_n;
      fault_p1      <= fault_n;
      WriteSrc_p1   <= WriteSrc_i;
      ALUout_p1     <= ALUout_i;
      DataMemOut_p1 <= (done & ~MemWrite_i) ? load_data : '0;
      pcPlus4_p1    <= pcPlus4_i;
      ImmOp_p1      <= ImmOp_i;
      rd_p1         <= rd_i;
    end
  end

  assign valid_o      = vld_p1;
  assign RegWrite_o   = RegWrite_p1;
  assign fault_o      = fault_p1;
  assign WriteSrc_o   = WriteSrc_p1;
  assign ALUout_o     = ALUout_p1;
  assign DataMemOut_o = DataMemOut_p1;
  assign pcPlus4_o    = pcPlus4_p1;
  assign ImmOp_o      = ImmOp_p1;
  assign rd_o         = rd_p1;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: ALU pass-through, store lanes, load extension,
// misalignment, bus timeout (TIMEOUT_CYCLES=4) and reset during an outstanding request.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, RegWrite_i, MemRead_i, MemWrite_i;
  logic [1:0]  WriteSrc_i;
  logic [2:0]  funct3_i;
  logic [31:0] ALUout_i, WriteData_i, pcPlus4_i, ImmOp_i;
  logic [4:0]  rd_i;
  logic        stall_o, valid_o, RegWrite_o, fault_o;
  logic [1:0]  WriteSrc_o;
  logic [31:0] ALUout_o, DataMemOut_o, pcPlus4_o, ImmOp_o;
  logic [4:0]  rd_o;
  int          tests = 0;
  int          fails = 0;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .RegWrite_i(RegWrite_i), .WriteSrc_i(WriteSrc_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ALUout_i(ALUout_i),
    .WriteData_i(WriteData_i), .pcPlus4_i(pcPlus4_i), .ImmOp_i(ImmOp_i), .rd_i(rd_i),
    .dmem(bus.master), .stall_o(stall_o), .valid_o(valid_o), .RegWrite_o(RegWrite_o),
    .WriteSrc_o(WriteSrc_o), .ALUout_o(ALUout_o), .DataMemOut_o(DataMemOut_o),
    .pcPlus4_o(pcPlus4_o), .ImmOp_o(ImmOp_o), .rd_o(rd_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slot();
    valid_i = 0; RegWrite_i = 0; WriteSrc_i = 0; MemRead_i = 0; MemWrite_i = 0;
    funct3_i = 0; ALUout_i = 0; WriteData_i = 0; pcPlus4_i = 0; ImmOp_i = 0; rd_i = 0;
  endtask

  task automatic set_mem(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic rw,
                         input logic [4:0] rd);
    valid_i = 1; MemRead_i = rd_en; MemWrite_i = wr_en; funct3_i = f3; ALUout_i = addr;
    WriteData_i = wd; RegWrite_i = rw; WriteSrc_i = rd_en ? 2'd1 : 2'd0; rd_i = rd;
    pcPlus4_i = 32'h0000_1004; ImmOp_i = 32'h0000_0000;
  endtask

  task automatic test_reset();
    rst = 1; clear_slot();
    bus.ack = 0; bus.rdata = 0;
    step(); step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    tests++; if (RegWrite_o !== 1'b0) begin fails++; $display("FAIL reset_regwrite: got %b want 0", RegWrite_o); end
    tests++; if (fault_o !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", fault_o); end
    tests++; if (ALUout_o !== 32'h0) begin fails++; $display("FAIL reset_aluout: got %h want 0", ALUout_o); end
    tests++; if (bus.req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.req); end
    rst = 0;
  endtask

  task automatic test_alu();
    clear_slot();
    valid_i = 1; RegWrite_i = 1; ALUout_i = 32'h1234; rd_i = 5;
    pcPlus4_i = 32'h40; ImmOp_i = 32'h77; WriteSrc_i = 2'd3;
    #1;
    tests++; if (stall_o !== 1'b0 || bus.req !== 1'b0) begin fails++; $display("FAIL alu_nostall: stall %b req %b want 0 0", stall_o, bus.req); end
    step();
    tests++; if (ALUout_o !== 32'h1234) begin fails++; $display("FAIL alu_out: got %h want 00001234", ALUout_o); end
    tests++; if (rd_o !== 5'd5) begin fails++; $display("FAIL alu_rd: got %0d want 5", rd_o); end
    tests++; if (valid_o !== 1'b1 || RegWrite_o !== 1'b1) begin fails++; $display("FAIL alu_valid_rw: got %b %b want 1 1", valid_o, RegWrite_o); end
    tests++; if (pcPlus4_o !== 32'h40 || ImmOp_o !== 32'h77 || WriteSrc_o !== 2'd3) begin
      fails++; $display("FAIL alu_passthru: got %h %h %0d want 40 77 3", pcPlus4_o, ImmOp_o, WriteSrc_o); end
  endtask

  task automatic test_store_sb();
    set_mem(0, 1, 3'b000, 32'h103, 32'h0000_00AB, 0, 0);
    bus.ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.req !== 1'b1 || stall_o !== 1'b1) begin fails++; $display("FAIL sb_stall%0d: req %b stall %b want 1 1", i, bus.req, stall_o); end
      tests++; if (bus.be !== 4'b1000 || bus.wdata !== 32'hABAB_ABAB || bus.addr !== 32'h100 || bus.we !== 1'b1) begin
        fails++; $display("FAIL sb_lanes%0d: be %b wdata %h addr %h we %b want 1000 abababab 100 1", i, bus.be, bus.wdata, bus.addr, bus.we); end
      step();
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL sb_bubble%0d: valid %b want 0", i, valid_o); end
    end
    bus.ack = 1;
    #1;
    tests++; if (stall_o !== 1'b0 || bus.req !== 1'b1) begin fails++; $display("FAIL sb_ack: stall %b req %b want 0 1", stall_o, bus.req); end
    step();
    bus.ack = 0; clear_slot();
    tests++; if (valid_o !== 1'b1 || fault_o !== 1'b0 || RegWrite_o !== 1'b0) begin
      fails++; $display("FAIL sb_done: valid %b fault %b rw %b want 1 0 0", valid_o, fault_o, RegWrite_o); end
    #1;
    tests++; if (bus.req !== 1'b0) begin fails++; $display("FAIL sb_idle: req %b want 0", bus.req); end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3 [3] = '{3'b001, 3'b010, 3'b111};
    logic [31:0] ad [3] = '{32'h102, 32'h204, 32'h208};
    logic [31:0] wd [3] = '{32'h1234_ABCD, 32'hDEAD_BEEF, 32'h0102_0304};
    logic [3:0]  be [3] = '{4'b1100, 4'hF, 4'hF};
    logic [31:0] wx [3] = '{32'hABCD_ABCD, 32'hDEAD_BEEF, 32'h0102_0304};
    for (int i = 0; i < 3; i++) begin
      set_mem(0, 1, f3[i], ad[i], wd[i], 0, 0);
      bus.ack = 1;
      #1;
      tests++; if (bus.be !== be[i] || bus.wdata !== wx[i] || stall_o !== 1'b0) begin
        fails++; $display("FAIL store_lane%0d: be %b wdata %h stall %b want %b %h 0", i, bus.be, bus.wdata, stall_o, be[i], wx[i]); end
      step();
    end
    bus.ack = 0; clear_slot();
    step();
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ad [5] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100};
    logic [31:0] rv [5] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000, 32'h1234_5678};
    logic [3:0]  be [5] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'hF};
    logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h1234_5678};
    for (int i = 0; i < 5; i++) begin
      set_mem(1, 0, f3[i], ad[i], 0, 1, 5'd9);
      bus.rdata = rv[i]; bus.ack = 1;
      #1;
      tests++; if (bus.req !== 1'b1 || stall_o !== 1'b0 || bus.we !== 1'b0 || bus.be !== be[i]) begin
        fails++; $display("FAIL load_req%0d: req %b stall %b we %b be %b want 1 0 0 %b", i, bus.req, stall_o, bus.we, bus.be, be[i]); end
      step();
      tests++; if (DataMemOut_o !== ex[i] || valid_o !== 1'b1 || RegWrite_o !== 1'b1) begin
        fails++; $display("FAIL load_data%0d: got %h v %b rw %b want %h 1 1", i, DataMemOut_o, valid_o, RegWrite_o, ex[i]); end
    end
    bus.ack = 0; bus.rdata = 0; clear_slot();
    step();
  endtask

  task automatic test_misaligned();
    set_mem(1, 0, 3'b010, 32'h106, 0, 1, 5'd7);
    bus.ack = 0;
    #1;
    tests++; if (bus.req !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL mis_lw_req: req %b stall %b want 0 0", bus.req, stall_o); end
    step();
    tests++; if (fault_o !== 1'b1 || RegWrite_o !== 1'b0 || rd_o !== 5'd7 || valid_o !== 1'b1) begin
      fails++; $display("FAIL mis_lw_wb: fault %b rw %b rd %0d v %b want 1 0 7 1", fault_o, RegWrite_o, rd_o, valid_o); end
    set_mem(0, 1, 3'b001, 32'h101, 32'h55, 0, 5'd3);
    #1;
    tests++; if (bus.req !== 1'b0) begin fails++; $display("FAIL mis_sh_req: req %b want 0", bus.req); end
    step();
    tests++; if (fault_o !== 1'b1) begin fails++; $display("FAIL mis_sh_fault: got %b want 1", fault_o); end
    clear_slot();
    step();
    tests++; if (fault_o !== 1'b0) begin fails++; $display("FAIL mis_clear: fault %b want 0", fault_o); end
  endtask

  task automatic test_timeout();
    set_mem(1, 0, 3'b010, 32'h200, 0, 1, 5'd4);
    bus.ack = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL to_stall%0d: got %b want 1", i, stall_o); end
      step();
    end
    #1;
    tests++; if (bus.req !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL to_drop: req %b stall %b want 0 0", bus.req, stall_o); end
    step();
    tests++; if (fault_o !== 1'b1 || RegWrite_o !== 1'b0 || valid_o !== 1'b1) begin
      fails++; $display("FAIL to_fault: fault %b rw %b v %b want 1 0 1", fault_o, RegWrite_o, valid_o); end
    clear_slot();
    valid_i = 1; RegWrite_i = 1; ALUout_i = 32'h99; rd_i = 2;
    #1;
    tests++; if (stall_o !== 1'b0 || bus.req !== 1'b0) begin fails++; $display("FAIL to_resume: stall %b req %b want 0 0", stall_o, bus.req); end
    step();
    tests++; if (ALUout_o !== 32'h99 || fault_o !== 1'b0) begin fails++; $display("FAIL to_next: alu %h fault %b want 99 0", ALUout_o, fault_o); end
  endtask

  task automatic test_reset_wait();
    set_mem(0, 1, 3'b010, 32'h300, 32'hCAFE, 0, 0);
    bus.ack = 0;
    step();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL rw_wait: stall %b want 1", stall_o); end
    rst = 1;
    #1;
    tests++; if (bus.req !== 1'b0) begin fails++; $display("FAIL rw_drop: req %b want 0", bus.req); end
    step();
    tests++; if (valid_o !== 1'b0 || fault_o !== 1'b0 || RegWrite_o !== 1'b0 || ALUout_o !== 32'h0) begin
      fails++; $display("FAIL rw_outs: v %b f %b rw %b alu %h want 0 0 0 0", valid_o, fault_o, RegWrite_o, ALUout_o); end
    rst = 0; clear_slot(); bus.ack = 1;
    #1;
    tests++; if (bus.req !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL rw_lateack: req %b stall %b want 0 0", bus.req, stall_o); end
    step();
    bus.ack = 0;
    tests++; if (valid_o !== 1'b0 || fault_o !== 1'b0) begin fails++; $display("FAIL rw_after: v %b f %b want 0 0", valid_o, fault_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      clear_slot();
      valid_i = 1; RegWrite_i = 1; ALUout_i = 32'h100 + i; rd_i = 5'(10 + i);
      step();
      tests++; if (ALUout_o !== 32'h100 + i || rd_o !== 5'(10 + i) || valid_o !== 1'b1) begin
        fails++; $display("FAIL b2b%0d: alu %h rd %0d v %b want %h %0d 1", i, ALUout_o, rd_o, valid_o, 32'h100 + i, 10 + i); end
    end
    clear_slot();
    step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL b2b_invalid: v %b want 0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_sb();
    test_store_lanes();
    test_loads();
    test_misaligned();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
